// File: rtl/mux_tree_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined mux tree.
package mux_tree_pipe_pkg;

  function automatic int mux_clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  function automatic int mux_num_stages(input int lvl, input int reg_every);
    return (lvl + reg_every - 1) / reg_every;
  endfunction

  function automatic int mux_min(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// Lane bus into the mux tree and selected-lane bus out of it, both with valid/ready.
interface mux_tree_pipe_if import mux_tree_pipe_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 32
);
  localparam int SW = mux_clog2(N_IN);

  logic [N_IN*WIDTH-1:0] in_data;
  logic [SW-1:0]         in_sel;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SW-1:0]         out_sel;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/mux_tree_pipe_stage.sv
// One pipeline stage: resolves NLVL tree levels starting at level LVL0, then registers
// the surviving lanes, the full select tag and a valid bit behind a skid-free handshake.
module mux_tree_stage #(
  parameter int WIDTH    = 8,
  parameter int LANES_IN = 32,
  parameter int NLVL     = 1,
  parameter int LVL0     = 0,
  parameter int SW       = 5
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic [LANES_IN*WIDTH-1:0]            i_lanes,
  input  logic [SW-1:0]                        i_tag,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [(LANES_IN>>NLVL)*WIDTH-1:0]    o_lanes,
  output logic [SW-1:0]                        o_tag
);

  logic                                 r_valid;
  logic [(LANES_IN>>NLVL)*WIDTH-1:0]    r_lanes;
  logic [SW-1:0]                        r_tag;

  // Level l halves the lane count; pair (2k, 2k+1) is chosen by tag bit LVL0+l-1.
  for (genvar l = 0; l <= NLVL; l++) begin : g_lvl
    logic [(LANES_IN>>l)*WIDTH-1:0] w_v;
    if (l == 0) begin : g_leaf
      assign w_v = i_lanes;
    end else begin : g_node
      for (genvar k = 0; k < (LANES_IN>>l); k++) begin : g_mux
        assign w_v[k*WIDTH +: WIDTH] = i_tag[LVL0+l-1]
                                     ? g_lvl[l-1].w_v[(2*k+1)*WIDTH +: WIDTH]
                                     : g_lvl[l-1].w_v[(2*k)*WIDTH +: WIDTH];
      end
    end
  end

  assign o_ready = !r_valid || i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_lanes <= '0;
      r_tag   <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_lanes <= g_lvl[NLVL].w_v;
        r_tag   <= i_tag;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_lanes = r_lanes;
  assign o_tag   = r_tag;

endmodule

// File: rtl/mux_tree_pipe.sv
// N_IN:1 pipelined mux tree with valid/ready flow control and an optional
// internal scan counter that replaces the external lane select.
module mux_tree_pipe import mux_tree_pipe_pkg::*; #(
  parameter int WIDTH     = 8,
  parameter int N_IN      = 32,
  parameter int REG_EVERY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scan_en,
  input  logic             scan_clr,
  mux_tree_pipe_if.slave   bus
);

  localparam int LVL = mux_clog2(N_IN);
  localparam int S   = mux_num_stages(LVL, REG_EVERY);

  logic [LVL-1:0] r_scan_cnt;
  logic [LVL-1:0] w_esel;
  logic           w_accept;
  logic [S:0]     w_valid;
  logic [S:0]     w_ready;
  logic [LVL-1:0] w_tag [0:S];

  assign w_accept = bus.in_valid && w_ready[0];
  assign w_esel   = scan_en ? r_scan_cnt : bus.in_sel;

  // Clear beats increment; the accepted beat in the clearing cycle still used the old count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
    end else if (scan_clr) begin
      r_scan_cnt <= '0;
    end else if (w_accept && scan_en) begin
      r_scan_cnt <= r_scan_cnt + LVL'(1);
    end
  end

  assign w_valid[0] = bus.in_valid;
  assign w_tag[0]   = w_esel;
  assign w_ready[S] = bus.out_ready;

  for (genvar i = 0; i < S; i++) begin : g_stage
    localparam int L0  = i * REG_EVERY;
    localparam int NL  = mux_min(REG_EVERY, LVL - L0);
    localparam int LIN = N_IN >> L0;

    logic [LIN*WIDTH-1:0]        w_lanes_in;
    logic [(LIN>>NL)*WIDTH-1:0]  w_lanes_out;

    if (i == 0) begin : g_first
      assign w_lanes_in = bus.in_data;
    end else begin : g_next
      assign w_lanes_in = g_stage[i-1].w_lanes_out;
    end

    mux_tree_stage #(
      .WIDTH    (WIDTH),
      .LANES_IN (LIN),
      .NLVL     (NL),
      .LVL0     (L0),
      .SW       (LVL)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_valid[i]),
      .o_ready (w_ready[i]),
      .i_lanes (w_lanes_in),
      .i_tag   (w_tag[i]),
      .o_valid (w_valid[i+1]),
      .i_ready (w_ready[i+1]),
      .o_lanes (w_lanes_out),
      .o_tag   (w_tag[i+1])
    );
  end

  assign bus.in_ready  = w_ready[0];
  assign bus.out_data  = g_stage[S-1].w_lanes_out;
  assign bus.out_sel   = w_tag[S];
  assign bus.out_valid = w_valid[S];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench for mux_tree_pipe: REG_EVERY=1 main instance plus REG_EVERY=2 and 5
// instances that share the main stimulus during the latency/order test.
module tb_mux_tree_pipe;

  localparam int W  = 8;
  localparam int N  = 32;
  localparam int SW = 5;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] sel;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scanEn = 1'b0;
  logic scanClr = 1'b0;
  logic auxEn = 1'b0;
  logic randRdy = 1'b0;
  logic rdyVal = 1'b1;
  logic rndBit = 1'b1;
  logic [N*W-1:0] lanes;
  logic [SW-1:0] modelCnt = '0;

  beat_t q1[$];
  beat_t q2[$];
  beat_t q5[$];
  beat_t e1, e2, e5;

  int nCompared = 0;
  int nMismatched = 0;
  int cyc = 0;
  int accCount = 0;
  int lastPresent = 0;
  int firstPresent = 0;
  int firstV1 = 0, firstV2 = 0, firstV5 = 0, lastV1 = 0;
  bit arm1 = 0, arm2 = 0, arm5 = 0;
  bit prevStall = 0;
  logic [W-1:0]  prevData;
  logic [SW-1:0] prevSel;

  mux_tree_pipe_if #(.WIDTH(W), .N_IN(N)) bus1 ();
  mux_tree_pipe_if #(.WIDTH(W), .N_IN(N)) bus2 ();
  mux_tree_pipe_if #(.WIDTH(W), .N_IN(N)) bus5 ();

  mux_tree_pipe #(.WIDTH(W), .N_IN(N), .REG_EVERY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .scan_en(scanEn), .scan_clr(scanClr), .bus(bus1));
  mux_tree_pipe #(.WIDTH(W), .N_IN(N), .REG_EVERY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .scan_en(1'b0), .scan_clr(1'b0), .bus(bus2));
  mux_tree_pipe #(.WIDTH(W), .N_IN(N), .REG_EVERY(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .scan_en(1'b0), .scan_clr(1'b0), .bus(bus5));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) rndBit <= 1'($urandom_range(0, 1));

  assign bus1.in_data   = lanes;
  assign bus1.out_ready = randRdy ? rndBit : rdyVal;
  assign bus2.in_data   = lanes;
  assign bus2.in_sel    = bus1.in_sel;
  assign bus2.in_valid  = bus1.in_valid & auxEn;
  assign bus2.out_ready = 1'b1;
  assign bus5.in_data   = lanes;
  assign bus5.in_sel    = bus1.in_sel;
  assign bus5.in_valid  = bus1.in_valid & auxEn;
  assign bus5.out_ready = 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s: event happened, expected none", name);
  endtask

  // Presents one beat from a negedge; pushes the expectation the moment it is accepted.
  task automatic applyStimulus(input logic [SW-1:0] sel, input logic clr);
    logic [SW-1:0] esel;
    bit done;
    done = 0;
    bus1.in_sel   = sel;
    bus1.in_valid = 1'b1;
    scanClr       = clr;
    for (int t = 0; t < 200 && !done; t++) begin
      #1;
      if (bus1.in_ready) begin
        esel = scanEn ? modelCnt : sel;
        q1.push_back(beat_t'{data: lanes[esel*W +: W], sel: esel});
        if (auxEn && bus2.in_ready) q2.push_back(beat_t'{data: lanes[esel*W +: W], sel: esel});
        if (auxEn && bus5.in_ready) q5.push_back(beat_t'{data: lanes[esel*W +: W], sel: esel});
        if (clr) modelCnt = '0;
        else if (scanEn) modelCnt = modelCnt + 1'b1;
        lastPresent = cyc;
        accCount++;
        done = 1;
      end
      @(negedge clk);
    end
    scanClr = 1'b0;
    if (!done) failNow("accept_timeout");
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prevStall = 0;
    end else begin
      if (prevStall) begin
        checkOutput("hold_valid", 32'(bus1.out_valid), 1);
        checkOutput("hold_data", 32'(bus1.out_data), 32'(prevData));
        checkOutput("hold_sel", 32'(bus1.out_sel), 32'(prevSel));
      end
      if (bus1.out_valid && arm1) begin
        firstV1 = cyc;
        arm1 = 0;
      end
      if (bus1.out_valid && bus1.out_ready) begin
        if (q1.size() == 0) failNow("unexpected_beat1");
        else begin
          e1 = q1.pop_front();
          checkOutput("data1", 32'(bus1.out_data), 32'(e1.data));
          checkOutput("sel1", 32'(bus1.out_sel), 32'(e1.sel));
          lastV1 = cyc;
        end
      end
      prevStall = bus1.out_valid && !bus1.out_ready;
      prevData  = bus1.out_data;
      prevSel   = bus1.out_sel;
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_n && bus2.out_valid) begin
      if (arm2) begin
        firstV2 = cyc;
        arm2 = 0;
      end
      if (q2.size() == 0) failNow("unexpected_beat2");
      else begin
        e2 = q2.pop_front();
        checkOutput("data2", 32'(bus2.out_data), 32'(e2.data));
        checkOutput("sel2", 32'(bus2.out_sel), 32'(e2.sel));
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_n && bus5.out_valid) begin
      if (arm5) begin
        firstV5 = cyc;
        arm5 = 0;
      end
      if (q5.size() == 0) failNow("unexpected_beat5");
      else begin
        e5 = q5.pop_front();
        checkOutput("data5", 32'(bus5.out_data), 32'(e5.data));
        checkOutput("sel5", 32'(bus5.out_sel), 32'(e5.sel));
      end
    end
  end

  initial begin
    bus1.in_sel   = '0;
    bus1.in_valid = 1'b0;
    for (int k = 0; k < N; k++) lanes[k*W +: W] = 8'hA0 + 8'(k);

    repeat (3) @(negedge clk);
    checkOutput("rst_hold_valid", 32'(bus1.out_valid), 0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_out_valid", 32'(bus1.out_valid), 0);
    checkOutput("rst_out_data", 32'(bus1.out_data), 0);
    checkOutput("rst_out_sel", 32'(bus1.out_sel), 0);
    checkOutput("rst_in_ready", 32'(bus1.in_ready), 1);
    @(negedge clk);

    $display("[TB] lane sweep, three pipeline depths");
    arm1 = 1; arm2 = 1; arm5 = 1;
    auxEn = 1'b1;
    for (int i = 0; i < N; i++) begin
      applyStimulus(5'(i), 1'b0);
      if (i == 0) firstPresent = lastPresent;
    end
    bus1.in_valid = 1'b0;
    auxEn = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("latency_re1", 32'(firstV1 - firstPresent), 5);
    checkOutput("latency_re2", 32'(firstV2 - firstPresent), 3);
    checkOutput("latency_re5", 32'(firstV5 - firstPresent), 1);
    checkOutput("throughput", 32'(lastV1 - firstV1), 31);
    checkOutput("sweep_left1", 32'(q1.size()), 0);
    checkOutput("sweep_left2", 32'(q2.size()), 0);
    checkOutput("sweep_left5", 32'(q5.size()), 0);

    $display("[TB] downstream stall");
    rdyVal = 1'b0;
    accCount = 0;
    fork
      begin
        for (int i = 0; i < 12; i++) applyStimulus(5'(i), 1'b0);
        bus1.in_valid = 1'b0;
      end
      begin
        repeat (10) @(negedge clk);
        #2;
        checkOutput("stall_accepts", 32'(accCount), 5);
        checkOutput("stall_in_ready", 32'(bus1.in_ready), 0);
        @(negedge clk);
        rdyVal = 1'b1;
      end
    join
    repeat (10) @(negedge clk);
    checkOutput("stall_left", 32'(q1.size()), 0);

    $display("[TB] scan counter wrap and clear");
    scanEn = 1'b1;
    for (int i = 0; i < 34; i++) applyStimulus(~5'(i), 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(5'd31, 1'b0);
    applyStimulus(5'd20, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(5'd17, 1'b0);
    bus1.in_valid = 1'b0;
    scanEn = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("scan_left", 32'(q1.size()), 0);

    $display("[TB] reset with beats in flight");
    for (int i = 0; i < 3; i++) applyStimulus(5'(i + 4), 1'b0);
    bus1.in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("flight_rst_valid", 32'(bus1.out_valid), 0);
    checkOutput("flight_rst_data", 32'(bus1.out_data), 0);
    checkOutput("flight_rst_sel", 32'(bus1.out_sel), 0);
    q1.delete();
    modelCnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("flight_rel_ready", 32'(bus1.in_ready), 1);
    checkOutput("flight_rel_valid", 32'(bus1.out_valid), 0);
    repeat (8) @(negedge clk);
    scanEn = 1'b1;
    applyStimulus(5'd9, 1'b0);
    bus1.in_valid = 1'b0;
    scanEn = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("flight_left", 32'(q1.size()), 0);

    $display("[TB] random valid/ready traffic");
    randRdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < N; k++) lanes[k*W +: W] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        bus1.in_valid = 1'b0;
        @(negedge clk);
      end
      applyStimulus(5'($urandom_range(0, N - 1)), 1'b0);
    end
    bus1.in_valid = 1'b0;
    randRdy = 1'b0;
    for (int t = 0; t < 100 && q1.size() != 0; t++) @(negedge clk);
    repeat (2) @(negedge clk);
    checkOutput("final_left", 32'(q1.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
    nMismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
